// File: rtl/fifo_xfer_ctrl_pkg.sv
// Shared definitions for the UART-to-FIFO transfer sequencer: command and status codes,
// FSM state encoding and the registered output bundle.
package fifo_xfer_ctrl_pkg;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] CMD_CLR = 8'h03;

    localparam logic [1:0] STATUS_OK        = 2'd0;
    localparam logic [1:0] STATUS_OVERFLOW  = 2'd1;
    localparam logic [1:0] STATUS_UNDERFLOW = 2'd2;
    localparam logic [1:0] STATUS_BAD_CMD   = 2'd3;

    // Number of header bytes the parser consumes before cmd/rx_cnt are valid.
    localparam logic [1:0] HDR_LEN = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_HDR      = 3'd0;
    localparam state_t ST_DECODE   = 3'd1;
    localparam state_t ST_WRITE    = 3'd2;
    localparam state_t ST_RD_ISSUE = 3'd3;
    localparam state_t ST_RD_WAIT  = 3'd4;
    localparam state_t ST_CLEAR    = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    typedef struct packed {
        logic       fifo_wr;
        logic [7:0] fifo_wdata;
        logic       fifo_rd;
        logic       fifo_clr;
        logic       tx_start;
        logic [7:0] tx_data;
        logic       fifo_done;
        logic [1:0] status;
    } xfer_out_t;

    function automatic logic is_xfer_cmd(input logic [7:0] c);
        return (c == CMD_WR) || (c == CMD_RD);
    endfunction

endpackage

// File: rtl/fifo_xfer_ctrl_if.sv
// Bundle of UART RX/TX, parser and FIFO signals seen by the transfer sequencer.
interface fifo_xfer_ctrl_if;

    logic        rok;
    logic [7:0]  mosi;
    logic [7:0]  cmd;
    logic [15:0] rx_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        tx_busy;

    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic        fifo_rd;
    logic        fifo_clr;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        fifo_done;
    logic [1:0]  status;

    modport master (
        input  rok, mosi, cmd, rx_cnt, fifo_full, fifo_empty, fifo_rdata, tx_busy,
        output fifo_wr, fifo_wdata, fifo_rd, fifo_clr, tx_start, tx_data, fifo_done, status
    );

    modport slave (
        output rok, mosi, cmd, rx_cnt, fifo_full, fifo_empty, fifo_rdata, tx_busy,
        input  fifo_wr, fifo_wdata, fifo_rd, fifo_clr, tx_start, tx_data, fifo_done, status
    );

endinterface

// File: rtl/fifo_xfer_ctrl.sv
// Transfer sequencer: counts the command header, then runs a write, read or clear of
// rx_cnt bytes between UART and FIFO and reports completion with a status code.
module fifo_xfer_ctrl
    import fifo_xfer_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_xfer_ctrl_if.master      bus
);

    state_t      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] remaining_q, remaining_d;
    logic        guard_q, guard_d;
    xfer_out_t   out_q, out_d;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        remaining_d = remaining_q;
        guard_d     = guard_q;

        // Strobes default low; data and status hold their last value.
        out_d            = '0;
        out_d.fifo_wdata = out_q.fifo_wdata;
        out_d.tx_data    = out_q.tx_data;
        out_d.status     = out_q.status;

        case (state_q)
            ST_HDR: begin
                if (bus.rok) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == HDR_LEN - 2'd1) begin
                        state_d = ST_DECODE;
                    end
                end
            end

            ST_DECODE: begin
                remaining_d  = bus.rx_cnt;
                out_d.status = STATUS_OK;
                if (bus.cmd == CMD_CLR) begin
                    state_d = ST_CLEAR;
                end else if (is_xfer_cmd(bus.cmd)) begin
                    if (bus.rx_cnt == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (bus.cmd == CMD_WR) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    out_d.status = STATUS_BAD_CMD;
                    state_d      = ST_DONE;
                end
            end

            ST_WRITE: begin
                if (bus.rok) begin
                    if (!bus.fifo_full) begin
                        out_d.fifo_wr    = 1'b1;
                        out_d.fifo_wdata = bus.mosi;
                    end else begin
                        out_d.status = STATUS_OVERFLOW;
                    end
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RD_ISSUE: begin
                if (bus.fifo_empty) begin
                    out_d.status = STATUS_UNDERFLOW;
                    state_d      = ST_DONE;
                end else if (!bus.tx_busy) begin
                    out_d.tx_start = 1'b1;
                    out_d.fifo_rd  = 1'b1;
                    out_d.tx_data  = bus.fifo_rdata;
                    remaining_d    = remaining_q - 16'd1;
                    guard_d        = 1'b1;
                    state_d        = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // First cycle is skipped so a late-rising tx_busy is not missed.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    state_d = (remaining_q == 16'd0) ? ST_DONE : ST_RD_ISSUE;
                end
            end

            ST_CLEAR: begin
                out_d.fifo_clr = 1'b1;
                out_d.status   = STATUS_OK;
                state_d        = ST_DONE;
            end

            ST_DONE: begin
                out_d.fifo_done = 1'b1;
                hdr_cnt_d       = 2'd0;
                state_d         = ST_HDR;
            end

            default: begin
                state_d   = ST_HDR;
                hdr_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            hdr_cnt_q   <= 2'd0;
            remaining_q <= 16'd0;
            guard_q     <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            remaining_q <= remaining_d;
            guard_q     <= guard_d;
            out_q       <= out_d;
        end
    end

    assign bus.fifo_wr    = out_q.fifo_wr;
    assign bus.fifo_wdata = out_q.fifo_wdata;
    assign bus.fifo_rd    = out_q.fifo_rd;
    assign bus.fifo_clr   = out_q.fifo_clr;
    assign bus.tx_start   = out_q.tx_start;
    assign bus.tx_data    = out_q.tx_data;
    assign bus.fifo_done  = out_q.fifo_done;
    assign bus.status     = out_q.status;

endmodule

// File: tb/tb_fifo_xfer_ctrl.sv
// Directed bench for fifo_xfer_ctrl with a behavioural FIFO and UART TX model around it.
module tb_fifo_xfer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_xfer_ctrl_if bus ();

    fifo_xfer_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Environment model state, owned by the negedge process below.
    logic [7:0] q[$];
    logic [7:0] wr_log[$];
    logic [7:0] tx_log[$];
    int         done_cnt, rd_cnt, clr_cnt, overlap_cnt, busy_viol, done_cyc;
    logic [1:0] done_status;
    int         busy_cnt;
    bit         busy_pend, busy;
    int         env_ack_seq = 0;

    // Requests from the stimulus process.
    int         env_req_seq = 0;
    int         env_preload = 0;
    bit         env_full    = 1'b0;

    always @(negedge clk) begin
        if (env_req_seq != env_ack_seq) begin
            q.delete();
            for (int i = 0; i < env_preload; i++) q.push_back(8'(8'h11 * (i + 1)));
            wr_log.delete();
            tx_log.delete();
            done_cnt = 0; rd_cnt = 0; clr_cnt = 0; overlap_cnt = 0; busy_viol = 0;
            done_cyc = 0; done_status = 2'd0;
            busy_cnt = 0; busy_pend = 1'b0; busy = 1'b0;
            env_ack_seq = env_req_seq;
        end else begin
            if (bus.fifo_wr) begin
                wr_log.push_back(bus.fifo_wdata);
                if (q.size() < 16) q.push_back(bus.fifo_wdata);
            end
            if (bus.fifo_rd) begin
                rd_cnt++;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (bus.fifo_clr) begin
                clr_cnt++;
                q.delete();
            end
            if (bus.fifo_done) begin
                done_cnt++;
                done_status = bus.status;
                done_cyc = cyc;
            end
            if ($countones({bus.fifo_wr, bus.tx_start, bus.fifo_clr, bus.fifo_done}) > 1 ||
                bus.fifo_rd != bus.tx_start) overlap_cnt++;
            // TX busy rises one cycle after tx_start and lasts four cycles.
            if (busy_pend) begin
                busy = 1'b1; busy_cnt = 4; busy_pend = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy = 1'b0;
            end
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_data);
                if (busy) busy_viol++;
                busy_pend = 1'b1;
            end
        end
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_rdata = (q.size() == 0) ? 8'h00 : q[0];
        bus.fifo_full  = env_full || (q.size() >= 16);
        bus.tx_busy    = busy;
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] len;
        int          npay;
        int          preload;
        bit          full;
        int          exp_wr;
        int          exp_tx;
        int          exp_clr;
        logic [1:0]  exp_st;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    int last_rok_cyc = 0;
    int hdr_cyc = 0;

    function automatic logic [7:0] pay(input int i);
        return 8'(8'hAA + 8'h11 * i);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rok = 1'b1;
        bus.mosi = b;
        last_rok_cyc = cyc;
        @(negedge clk);
        bus.rok = 1'b0;
        @(negedge clk);
    endtask

    task automatic env_setup(input int preload, input bit full);
        @(posedge clk);
        env_preload = preload;
        env_full = full;
        env_req_seq++;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [15:0] len);
        bus.cmd = c;
        bus.rx_cnt = len;
        send_byte(c);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        hdr_cyc = last_rok_cyc;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
    endtask

    task automatic chk_outs_zero(input string name);
        chk(name, int'({bus.fifo_wr, bus.fifo_wdata, bus.fifo_rd, bus.fifo_clr, bus.tx_start,
                        bus.tx_data, bus.fifo_done, bus.status}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h01, 16'd3, 3, 0,  1'b0, 3, 0, 0, 2'd0, 0};
        vecs[1]  = '{8'h02, 16'd2, 0, 2,  1'b0, 0, 2, 0, 2'd0, 0};
        vecs[2]  = '{8'h01, 16'd2, 2, 0,  1'b1, 0, 0, 0, 2'd1, 0};
        vecs[3]  = '{8'h02, 16'd3, 0, 1,  1'b0, 0, 1, 0, 2'd2, 0};
        vecs[4]  = '{8'h7F, 16'd5, 0, 0,  1'b0, 0, 0, 0, 2'd3, 3};
        vecs[5]  = '{8'h01, 16'd0, 0, 0,  1'b0, 0, 0, 0, 2'd0, 3};
        vecs[6]  = '{8'h03, 16'd5, 0, 4,  1'b0, 0, 0, 1, 2'd0, 4};
        vecs[7]  = '{8'h01, 16'd3, 3, 15, 1'b0, 1, 0, 0, 2'd1, 0};
        vecs[8]  = '{8'h02, 16'd0, 0, 2,  1'b0, 0, 0, 0, 2'd0, 3};
        vecs[9]  = '{8'h00, 16'd1, 0, 0,  1'b0, 0, 0, 0, 2'd3, 3};
        vecs[10] = '{8'h02, 16'd1, 0, 3,  1'b0, 0, 1, 0, 2'd0, 0};

        bus.rok = 1'b0;
        bus.mosi = 8'h00;
        bus.cmd = 8'h00;
        bus.rx_cnt = 16'd0;

        rst_n = 1'b0;
        env_setup(0, 1'b0);
        #1;
        chk_outs_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int v = 0; v < NVEC; v++) begin
            env_setup(vecs[v].preload, vecs[v].full);
            send_hdr(vecs[v].cmd, vecs[v].len);
            for (int i = 0; i < vecs[v].npay; i++) send_byte(pay(i));
            wait_done();
            chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            chk($sformatf("v%0d_status", v), int'(done_status), int'(vecs[v].exp_st));
            chk($sformatf("v%0d_wr_cnt", v), wr_log.size(), vecs[v].exp_wr);
            for (int j = 0; j < wr_log.size() && j < vecs[v].exp_wr; j++)
                chk($sformatf("v%0d_wdata%0d", v, j), int'(wr_log[j]), int'(pay(j)));
            chk($sformatf("v%0d_tx_cnt", v), tx_log.size(), vecs[v].exp_tx);
            for (int j = 0; j < tx_log.size() && j < vecs[v].exp_tx; j++)
                chk($sformatf("v%0d_txdata%0d", v, j), int'(tx_log[j]), 8'h11 * (j + 1));
            chk($sformatf("v%0d_rd_cnt", v), rd_cnt, vecs[v].exp_tx);
            chk($sformatf("v%0d_clr_cnt", v), clr_cnt, vecs[v].exp_clr);
            if (vecs[v].exp_lat > 0)
                chk($sformatf("v%0d_latency", v), done_cyc - hdr_cyc, vecs[v].exp_lat);
            chk($sformatf("v%0d_strobe_overlap", v), overlap_cnt, 0);
            chk($sformatf("v%0d_tx_while_busy", v), busy_viol, 0);
        end

        // Reset in the middle of a 5-byte write, then a clear must work from a clean header.
        env_setup(0, 1'b0);
        send_hdr(8'h01, 16'd5);
        send_byte(pay(0));
        send_byte(pay(1));
        rst_n = 1'b0;
        #1;
        chk_outs_zero("midxfer_reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("midxfer_no_done", done_cnt, 0);
        chk("midxfer_wr_cnt", wr_log.size(), 2);
        chk("midxfer_overlap", overlap_cnt, 0);
        send_hdr(8'h03, 16'd0);
        wait_done();
        chk("post_reset_clr_cnt", clr_cnt, 1);
        chk("post_reset_done_cnt", done_cnt, 1);
        chk("post_reset_status", int'(done_status), 0);
        chk("post_reset_latency", done_cyc - hdr_cyc, 4);

        // Back-to-back: a write straight after a read, with no gap beyond the header pacing.
        env_setup(2, 1'b0);
        send_hdr(8'h02, 16'd2);
        wait_done();
        chk("b2b_rd_tx_cnt", tx_log.size(), 2);
        send_hdr(8'h01, 16'd1);
        send_byte(8'h5C);
        wait_done();
        chk("b2b_done_cnt", done_cnt, 2);
        chk("b2b_wr_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("b2b_wdata", int'(wr_log[0]), 8'h5C);
        chk("b2b_status", int'(done_status), 0);
        chk("b2b_tx_while_busy", busy_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
